// File: rtl/mask_encode_pkg.sv
// Shared constants and FSM state type for the mask encoder.
package mask_encode_pkg;

  localparam int MASK_W = 32;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mask_chunk_scan.sv
// Combinational scan of one SCAN_W-bit chunk: any-set, first/last set index,
// count of 0->1 transitions (seeded by the previous bit) and the chunk's top bit.
module mask_chunk_scan
  import mask_encode_pkg::*;
#(
  parameter int SCAN_W = 4
) (
  input  logic [SCAN_W-1:0] chunk,
  input  logic [IDX_W-1:0]  base,
  input  logic              prev_bit,
  output logic              any_set,
  output logic [IDX_W-1:0]  first_idx,
  output logic [IDX_W-1:0]  last_idx,
  output logic [CNT_W-1:0]  rise_cnt,
  output logic              last_bit
);

  logic p;

  assign any_set  = |chunk;
  assign last_bit = chunk[SCAN_W-1];

  always_comb begin
    first_idx = '0;
    last_idx  = '0;
    rise_cnt  = '0;
    p         = prev_bit;
    // Walking downward leaves the lowest set position in first_idx.
    for (int unsigned i = SCAN_W; i > 0; i--) begin
      if (chunk[i-1]) first_idx = base + IDX_W'(i - 1);
    end
    for (int unsigned i = 0; i < SCAN_W; i++) begin
      if (chunk[i]) last_idx = base + IDX_W'(i);
      if (chunk[i] && !p) rise_cnt = rise_cnt + CNT_W'(1);
      p = chunk[i];
    end
  end

endmodule

// File: rtl/mask_encode.sv
// Multi-cycle mask encoder: scans a 32-bit mask SCAN_W bits per cycle and
// reports lowest/highest set index, single-run flag and all-zero flag.
module mask_encode
  import mask_encode_pkg::*;
#(
  parameter int SCAN_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MASK_W-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_right,
  output logic [IDX_W-1:0]  out_left,
  output logic              out_contig,
  output logic              out_zero
);

  localparam logic [IDX_W-1:0] STEP      = IDX_W'(SCAN_W);
  localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(MASK_W - SCAN_W);

  state_t state, state_n;
  logic   accept, finish;
  logic   rdy_q;

  logic [MASK_W-1:0] shift_q;
  logic [IDX_W-1:0]  base_q;
  logic [IDX_W-1:0]  right_q, left_q;
  logic              seen_q, prev_q;
  logic [CNT_W-1:0]  rise_q;

  logic              c_any, c_last_bit;
  logic [IDX_W-1:0]  c_first, c_last;
  logic [CNT_W-1:0]  c_rise;

  logic [IDX_W-1:0]  right_n, left_n;
  logic              seen_n;
  logic [CNT_W-1:0]  rise_n;

  mask_chunk_scan #(.SCAN_W(SCAN_W)) u_scan (
    .chunk     (shift_q[SCAN_W-1:0]),
    .base      (base_q),
    .prev_bit  (prev_q),
    .any_set   (c_any),
    .first_idx (c_first),
    .last_idx  (c_last),
    .rise_cnt  (c_rise),
    .last_bit  (c_last_bit)
  );

  // Fold the current chunk into the running result.
  always_comb begin
    right_n = right_q;
    left_n  = left_q;
    seen_n  = seen_q | c_any;
    rise_n  = rise_q + c_rise;
    if (c_any) begin
      left_n = c_last;
      if (!seen_q) right_n = c_first;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && rdy_q) begin
          state_n = SCAN;
          accept  = 1'b1;
        end
      end
      SCAN: begin
        if (base_q == LAST_BASE) begin
          state_n = DONE;
          finish  = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state == DONE);

  // rdy_q is registered so in_ready rises on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      shift_q    <= '0;
      base_q     <= '0;
      right_q    <= '0;
      left_q     <= '0;
      seen_q     <= 1'b0;
      prev_q     <= 1'b0;
      rise_q     <= '0;
      out_right  <= '0;
      out_left   <= '0;
      out_contig <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n == IDLE);
      if (accept) begin
        shift_q <= in_mask;
        base_q  <= '0;
        right_q <= '0;
        left_q  <= '0;
        seen_q  <= 1'b0;
        prev_q  <= 1'b0;
        rise_q  <= '0;
      end else if (state == SCAN) begin
        shift_q <= shift_q >> SCAN_W;
        base_q  <= base_q + STEP;
        right_q <= right_n;
        left_q  <= left_n;
        seen_q  <= seen_n;
        prev_q  <= c_last_bit;
        rise_q  <= rise_n;
      end
      if (finish) begin
        out_right  <= right_n;
        out_left   <= left_n;
        out_contig <= (rise_n == CNT_W'(1));
        out_zero   <= !seen_n;
      end
    end
  end

endmodule
